// File: rtl/comparator_search_pkg.sv
// Shared types and constants for the comparator_search block.
package comparator_search_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } search_state_t;

  localparam int HIT_COUNT_W = 16;

endpackage

// File: rtl/comparator_eq.sv
// N-bit equality comparator shared by the sequential table search.
module comparator_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comparator_search.sv
// Sequential first-match search over a DEPTH-entry key table using one
// shared equality comparator, one entry per cycle, lowest index wins.
// Optional hit counter output enabled by defining COMPARATOR_SEARCH_HIT_COUNT_EN.
module comparator_search
  import comparator_search_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ena,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [N-1:0]     wr_data,
  input  logic             wr_valid,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_index
`ifdef COMPARATOR_SEARCH_HIT_COUNT_EN
  ,
  output logic [HIT_COUNT_W-1:0] hit_count
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [N-1:0]     entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  search_state_t    state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     key_q, key_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eq;
  logic             wr_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < (IDX_W + 1)'(DEPTH));

  comparator_eq #(.N(N)) u_cmp (
    .a_i  (entry_q[ptr_q]),
    .b_i  (key_q),
    .eq_o (eq)
  );

  // Table data storage; a write becomes visible to compares from the next cycle.
  // NOTE: the data array has no reset so it maps onto plain RAM/flops without
  // a reset tree; the valid bits alone decide whether an entry can match.
  always_ff @(posedge clk) begin
    if (wr_ena && wr_in_range) begin
      entry_q[wr_addr] <= wr_data;
    end
  end

  // Per-entry valid bits, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_ena && wr_in_range) begin
      valid_q[wr_addr] <= wr_valid;
    end
  end

  // Next-state and datapath decode for the scan controller.
  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    key_d   = key_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          key_d   = req_key;
          ptr_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (valid_q[ptr_q] && eq) begin
          hit_d   = 1'b1;
          idx_d   = ptr_q;
          state_d = S_DONE;
        end else if (ptr_q == LAST_IDX) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointer, latched key and registered result.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      key_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      key_q   <= key_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_hit   = hit_q;
  assign rsp_index = idx_q;

`ifdef COMPARATOR_SEARCH_HIT_COUNT_EN
  logic [HIT_COUNT_W-1:0] hit_cnt_q;

  // Saturating count of hit responses that completed their handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q <= '0;
    end else if ((state_q == S_DONE) && rsp_ready && hit_q && (hit_cnt_q != '1)) begin
      hit_cnt_q <= hit_cnt_q + 1'b1;
    end
  end

  assign hit_count = hit_cnt_q;
`endif

endmodule

// File: tb/tb_comparator_search.sv
// Self-checking bench for comparator_search (N=32, DEPTH=8): directed cases
// with literal expectations plus randomized searches against a table model.
module tb_comparator_search;

  localparam int N     = 32;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_ena = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_key = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_hit;
  logic [2:0]  rsp_index;
`ifdef COMPARATOR_SEARCH_HIT_COUNT_EN
  logic [15:0] hit_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  comparator_search #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_index (rsp_index)
`ifdef COMPARATOR_SEARCH_HIT_COUNT_EN
    ,
    .hit_count (hit_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 searching, 2 result pending. The outcome of a search is
  // decided at acceptance from the table contents (the driver never writes
  // while a search is outstanding) and the response appears after the
  // latency the scan rules imply: index k -> k+1 edges, miss -> DEPTH edges.
  logic [31:0] m_data  [DEPTH];
  bit          m_valid [DEPTH];
  int          m_phase;
  int          m_wait;
  bit          m_hit;
  int          m_idx;
  int unsigned m_hits;
  bit          preload = 1'b0;

  function automatic int find_first(input logic [31:0] key);
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && (m_data[i] == key)) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] <= 1'b0;
      m_phase <= 0;
      m_wait  <= 0;
      m_hit   <= 1'b0;
      m_idx   <= 0;
      m_hits  <= 0;
    end else begin
      if (wr_ena) begin
        m_data[wr_addr]  <= wr_data;
        m_valid[wr_addr] <= wr_valid;
      end
      if (preload) m_hits <= 32'hFFFE;
      case (m_phase)
        0: if (req_valid) begin
          int f;
          f = find_first(req_key);
          m_phase <= 1;
          m_hit   <= (f >= 0);
          m_idx   <= (f >= 0) ? f : 0;
          m_wait  <= (f >= 0) ? f + 1 : DEPTH;
        end
        1: begin
          if (m_wait == 1) m_phase <= 2;
          m_wait <= m_wait - 1;
        end
        default: if (rsp_ready) begin
          m_phase <= 0;
          if (m_hit && m_hits < 32'hFFFF) m_hits <= m_hits + 1;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, m_phase == 0});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_phase == 2});
      if (m_phase == 2) begin
        check("rsp_hit", {31'd0, rsp_hit}, {31'd0, m_hit});
        check("rsp_index", {29'd0, rsp_index}, m_idx);
      end
`ifdef COMPARATOR_SEARCH_HIT_COUNT_EN
      check("hit_count", {16'd0, hit_count}, m_hits);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_entry(input int addr, input logic [31:0] data, input bit vld);
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = addr[2:0]; wr_data = data; wr_valid = vld;
    @(posedge clk);
    #1 wr_ena = 1'b0;
  endtask

  // exp_lat < 0 skips the literal checks (randomized use).
  task automatic search(input logic [31:0] key, input int exp_lat, input int exp_hit,
                        input int exp_idx, input int hold);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_key = key;
    @(posedge clk);
    #1 req_valid = 1'b0; req_key = $urandom;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      if (lat > 40) begin
        check("rsp_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (exp_lat >= 0) begin
      check("latency", lat, exp_lat);
      check("lit_hit", {31'd0, rsp_hit}, exp_hit);
      check("lit_index", {29'd0, rsp_index}, exp_idx);
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_key = key;
      @(negedge clk);
      if (exp_lat >= 0) begin
        check("hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_index", {29'd0, rsp_index}, exp_idx);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  logic [31:0] pool [4];

  initial begin
    pool[0] = 32'h0000_00AA; pool[1] = 32'hCAFE_F00D;
    pool[2] = 32'h1357_9BDF; pool[3] = 32'h8000_0001;

    // Reset values.
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_hit", {31'd0, rsp_hit}, 32'd0);
    check("rst_rsp_index", {29'd0, rsp_index}, 32'd0);
    @(posedge clk); #2 rst = 1'b1;

    // Empty table miss: t+1+DEPTH.
    search(32'h0000_1234, 9, 0, 0, 0);
    // Single hit at index 3: t+2+3.
    write_entry(3, 32'hDEAD_BEEF, 1'b1);
    search(32'hDEAD_BEEF, 5, 1, 3, 0);
    // Duplicate entries, lower one invalidated: index 6 wins.
    write_entry(2, 32'hA5A5_A5A5, 1'b1);
    write_entry(6, 32'hA5A5_A5A5, 1'b1);
    write_entry(2, 32'hA5A5_A5A5, 1'b0);
    search(32'hA5A5_A5A5, 8, 1, 6, 0);
    // Both duplicates valid: lowest index wins.
    write_entry(2, 32'hA5A5_A5A5, 1'b1);
    search(32'hA5A5_A5A5, 4, 1, 2, 0);
    // Back-pressure: held result, req_valid pulses ignored.
    search(32'hDEAD_BEEF, 5, 1, 3, 4);

    // Reset while scanning at ptr=4.
    write_entry(2, 32'hA5A5_A5A5, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_key = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_rsp_hit", {31'd0, rsp_hit}, 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    // Table valid bits cleared: previously present keys now miss.
    search(32'hA5A5_A5A5, 9, 0, 0, 0);
    search(32'hDEAD_BEEF, 9, 0, 0, 0);

`ifdef COMPARATOR_SEARCH_HIT_COUNT_EN
    write_entry(1, 32'h0BAD_F00D, 1'b1);
    search(32'h0BAD_F00D, 3, 1, 1, 0);
    search(32'h0000_0000, 9, 0, 0, 0);
    search(32'h0BAD_F00D, 3, 1, 1, 1);
    search(32'hFFFF_FFFF, 9, 0, 0, 0);
    search(32'h0BAD_F00D, 3, 1, 1, 0);
    check("hit_count_3", {16'd0, hit_count}, 32'd3);
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFFE;
    preload = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;
    release dut.hit_cnt_q;
    search(32'h0BAD_F00D, 3, 1, 1, 0);
    search(32'h0BAD_F00D, 3, 1, 1, 0);
    check("hit_count_sat", {16'd0, hit_count}, 32'h0000_FFFF);
`endif

    // Randomized traffic checked cycle by cycle against the model.
    for (int it = 0; it < 40; it++) begin
      int nw;
      logic [31:0] key;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        write_entry($urandom_range(0, DEPTH - 1), pool[$urandom_range(0, 3)],
                    ($urandom_range(0, 3) != 0));
      end
      key = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 3)];
      search(key, -1, -1, -1, $urandom_range(0, 2));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_search.md
Name: comparator_search

Overview:
- Sequential first-match search controller over a small key table, built around one shared `comparator_eq` instance.
- A request carries an N-bit key. The block scans table entries one per cycle through the single comparator, then returns hit/miss and the lowest matching index.
- Sits between a requester, such as a tag/lookup unit, and the table write port. Trades latency for area versus a fully parallel compare.

Parameters:
- N, 32, key/entry width in bits; passed through to `comparator_eq`.
- DEPTH, 8, number of table entries; any value >= 2.
- IDX_W, $clog2(DEPTH), index width (localparam, derived).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_ena  input  1  table write enable.
- wr_addr  input  IDX_W  entry to write; addresses >= DEPTH are ignored.
- wr_data  input  N  entry value.
- wr_valid  input  1  valid bit stored with the entry; 0 invalidates the entry.
- req_valid  input  1  search request present.
- req_ready  output  1  block can accept a request.
- req_key  input  N  key to search for.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_hit  output  1  a valid entry equal to the key was found.
- rsp_index  output  IDX_W  lowest matching index; 0 on a miss.

Behaviour:
- Reset (rst low, asynchronous): all entry valid bits 0, state S_IDLE, req_ready=1, rsp_valid=0, rsp_hit=0, rsp_index=0, scan pointer 0. Entry data is not reset.
- FSM states: S_IDLE, S_SCAN, S_DONE.
- S_IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid & req_ready: latch req_key, set ptr=0, go to S_SCAN.
- S_SCAN:
  - req_ready=0. `comparator_eq` compares entry[ptr] against the latched key.
  - If entry_valid[ptr] & eq: rsp_hit<=1, rsp_index<=ptr, go to S_DONE.
  - Else if ptr==DEPTH-1: rsp_hit<=0, rsp_index<=0, go to S_DONE.
  - Else ptr<=ptr+1.
- S_DONE:
  - rsp_valid=1; rsp_hit and rsp_index are held stable while rsp_valid=1.
  - On rsp_ready: go to S_IDLE. The next request is accepted no earlier than the cycle after the response handshake; there is no bypass.
- Latency: request accepted in cycle t.
  - Hit at index k: rsp_valid first high in cycle t+2+k.
  - Miss: rsp_valid first high in cycle t+1+DEPTH.
- Multiple matches: the lowest index wins, because the scan is ascending and exits early.
- Table writes:
  - Accepted in any state; the new value is visible from the next cycle.
  - A write to entry[ptr] in the cycle it is compared does not affect that compare (old value is used).
  - A write to an index already scanned does not restart the scan.
- Key stability: req_key may change after acceptance; only the latched copy is used.
- Reset mid-scan or in S_DONE: the search is aborted, no response is produced, and outputs return to reset values.
- All outputs are registered or decoded from state only; no combinational path from req_valid or rsp_ready to any output.

Optional Feature:
- Macro: COMPARATOR_SEARCH_HIT_COUNT_EN.
- Defined:
  - Adds output port hit_count [15:0].
  - Increments by 1 on each response handshake (rsp_valid & rsp_ready) with rsp_hit=1; saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package comparator_search_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} search_state_t.
  - Localparam HIT_COUNT_W = 16.
- Sub-module: exactly one existing `comparator_eq` instance with #(.N(N)). No new sub-module.
- Table, valid bits, FSM, and pointer live in comparator_search.

Test Plan:
- Reset, then request key=32'h1234 with an empty table -> rsp_valid in cycle t+9 (DEPTH=8), rsp_hit=0, rsp_index=0.
- Write entry3=32'hDEAD_BEEF (valid), request 32'hDEADBEEF -> rsp_valid in cycle t+5, rsp_hit=1, rsp_index=3.
- Write entries 2 and 6 both = 32'hA5A5_A5A5, invalidate entry 2 with wr_valid=0, request 32'hA5A5A5A5 -> hit, rsp_index=6.
- Hold rsp_ready=0 for 4 cycles after rsp_valid -> rsp_valid, rsp_hit, rsp_index stable; req_ready=0 throughout; a req_valid pulse is not accepted.
- Assert rst low during S_SCAN at ptr=4 -> rsp_valid stays 0, req_ready=1 after release, table valid bits all 0, next search misses.
- With COMPARATOR_SEARCH_HIT_COUNT_EN: run 3 hits and 2 misses -> hit_count=3; preload the counter near 16'hFFFF via force -> hit_count holds at 16'hFFFF.
